// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready issue controller on the driving side of a combinational ALU.
// Decodes opcodes, registers ALU operands/control, captures Result/Zero and returns them.
module alu_issue_ctrl #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [n-1:0] in_a,
    input  logic [n-1:0] in_b,
    output logic [n-1:0] OPA,
    output logic [n-1:0] OPB,
    output logic [2:0]   ALUCtrl,
    input  logic [n-1:0] Result,
    input  logic         Zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic         out_zero,
    output logic         out_err,
    output logic [15:0]  ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {CLS_ALU, CLS_CMP, CLS_NOP, CLS_ILL} op_class_t;

    localparam logic [n-1:0] SHAMT_MASK = (n)'(n - 1);

    state_t       r_state, w_state_nxt;
    op_class_t    r_cls, w_dec_cls;
    logic [2:0]   w_dec_ctrl;
    logic [n-1:0] w_dec_opb;
    logic         w_accept, w_resp_done;

    logic [n-1:0] r_opa, r_opb, r_out_data;
    logic [2:0]   r_alu_ctrl;
    logic         r_out_valid, r_out_zero, r_out_err;
    logic [15:0]  r_ops_done;

    assign in_ready    = (r_state == IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_resp_done = r_out_valid & out_ready;

    // The opcode class decides later how the captured ALU outputs are used.
    always_comb begin
        w_dec_ctrl = 3'b000;
        w_dec_cls  = CLS_ILL;
        w_dec_opb  = in_b;
        case (in_op)
            4'd0: begin w_dec_ctrl = 3'b011; w_dec_cls = CLS_ALU; end
            4'd1: begin w_dec_ctrl = 3'b100; w_dec_cls = CLS_ALU; end
            4'd2: begin w_dec_ctrl = 3'b101; w_dec_cls = CLS_ALU; end
            4'd3: begin w_dec_ctrl = 3'b110; w_dec_cls = CLS_ALU; end
            4'd4: begin
                w_dec_ctrl = 3'b111;
                w_dec_cls  = CLS_ALU;
                w_dec_opb  = in_b & SHAMT_MASK;
            end
            4'd5: begin w_dec_ctrl = 3'b100; w_dec_cls = CLS_CMP; end
            4'd6: begin w_dec_ctrl = 3'b000; w_dec_cls = CLS_NOP; end
            default: begin w_dec_ctrl = 3'b000; w_dec_cls = CLS_ILL; end
        endcase
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_resp_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa       <= '0;
            r_opb       <= '0;
            r_alu_ctrl  <= 3'b000;
            r_cls       <= CLS_NOP;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b0;
            r_out_err   <= 1'b0;
            r_ops_done  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_opa      <= in_a;
                r_opb      <= w_dec_opb;
                r_alu_ctrl <= w_dec_ctrl;
                r_cls      <= w_dec_cls;
            end
            if (r_state == EXEC) begin
                r_alu_ctrl  <= 3'b000;
                r_out_valid <= 1'b1;
                case (r_cls)
                    CLS_ALU: begin r_out_data <= Result; r_out_zero <= Zero; r_out_err <= 1'b0; end
                    CLS_CMP: begin r_out_data <= '0;     r_out_zero <= Zero; r_out_err <= 1'b0; end
                    CLS_NOP: begin r_out_data <= '0;     r_out_zero <= 1'b1; r_out_err <= 1'b0; end
                    default: begin r_out_data <= '0;     r_out_zero <= 1'b1; r_out_err <= 1'b1; end
                endcase
            end
            if (w_resp_done) begin
                r_out_valid <= 1'b0;
                r_ops_done  <= r_ops_done + 16'd1;
            end
        end
    end

    assign OPA       = r_opa;
    assign OPB       = r_opb;
    assign ALUCtrl   = r_alu_ctrl;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;
    assign out_err   = r_out_err;
    assign ops_done  = r_ops_done;

endmodule
